// File: rtl/synapse_accum_8x.sv
// Presynaptic weighted-spike accumulator: on each step strobe, serially sums the
// weights of the latched spiking inputs (saturating) and presents the result with a valid pulse.
module synapse_accum_8x #(
    parameter int N_INPUTS = 8,
    parameter int AW       = 3,
    parameter int W_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               w_we,
    input  logic [AW-1:0]      w_addr,
    input  logic [W_WIDTH-1:0] w_data,
    input  logic [N_INPUTS-1:0] spike_in,
    input  logic               step,
    output logic               busy,
    output logic [W_WIDTH-1:0] post_synaptic,
    output logic               valid
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [AW-1:0]      LAST_IDX = AW'(N_INPUTS - 1);
    localparam logic [W_WIDTH-1:0] SAT_MAX  = {W_WIDTH{1'b1}};

    state_t                             state_q, state_d;
    logic [AW-1:0]                      idx_q, idx_d;
    logic [W_WIDTH-1:0]                 acc_q, acc_d;
    logic [N_INPUTS-1:0]                spike_lat_q, spike_lat_d;
    logic [W_WIDTH-1:0]                 post_q, post_d;
    logic                               valid_q, valid_d;
    logic                               busy_q, busy_d;
    logic [N_INPUTS-1:0][W_WIDTH-1:0]   weight_q, weight_d;

    logic [W_WIDTH-1:0]                 cur_weight;
    logic [W_WIDTH:0]                   sum_wide;
    logic [W_WIDTH-1:0]                 sum_sat;

    // Per-entry write decode; the scan reads weight_q, so a write landing on the
    // same edge as its read only takes effect for later reads.
    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_weight
            assign weight_d[gi] = (w_we && (w_addr == AW'(gi))) ? w_data : weight_q[gi];
        end
    endgenerate

    assign cur_weight = spike_lat_q[idx_q] ? weight_q[idx_q] : '0;
    assign sum_wide   = {1'b0, acc_q} + {1'b0, cur_weight};
    assign sum_sat    = sum_wide[W_WIDTH] ? SAT_MAX : sum_wide[W_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        spike_lat_d = spike_lat_q;
        post_d      = post_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (step) begin
                    spike_lat_d = spike_in;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = SCAN;
                    busy_d      = 1'b1;
                end
            end
            SCAN: begin
                acc_d = sum_sat;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    post_d  = sum_sat;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            spike_lat_q <= '0;
            post_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            weight_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            spike_lat_q <= spike_lat_d;
            post_q      <= post_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            weight_q    <= weight_d;
        end
    end

    assign busy          = busy_q;
    assign post_synaptic = post_q;
    assign valid         = valid_q;

endmodule

// File: tb/tb_synapse_accum_8x.sv
// Bench for synapse_accum_8x: directed scenarios plus randomized scans against a
// behavioural weighted-sum model.
module tb_synapse_accum_8x;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       w_we = 1'b0;
    logic [2:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic [7:0] spike_in = '0;
    logic       step = 1'b0;
    logic       busy;
    logic [7:0] post_synaptic;
    logic       valid;

    int checks = 0;
    int errors = 0;
    int w_m [N];

    synapse_accum_8x #(.N_INPUTS(8), .AW(3), .W_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .spike_in(spike_in), .step(step), .busy(busy),
        .post_synaptic(post_synaptic), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic write_w(input int a, input int d);
        @(negedge clk);
        w_we = 1'b1; w_addr = 3'(a); w_data = 8'(d);
        @(posedge clk); #1;
        w_we = 1'b0;
        w_m[a] = d;
    endtask

    // One full scan; optional stray steps at cycles 2 and 5, optional write at edge wr_cyc.
    task automatic run_scan(input string tag, input logic [7:0] sp, input bit noisy,
                            input int wr_cyc, input int wr_a, input int wr_d);
        int sum;
        int w_eff;
        int exp_ps;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            // index i is read at edge i+1; a write at edge wr_cyc is seen only if earlier
            w_eff = (wr_cyc > 0 && wr_a == i && wr_cyc <= i) ? wr_d : w_m[i];
            if (sp[i]) sum += w_eff;
        end
        exp_ps = (sum > 255) ? 255 : sum;
        @(negedge clk);
        spike_in = sp; step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        chk({tag, "_valid_start"}, 32'(valid), 32'd0);
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            if (c == 1) spike_in = ~sp;
            step = noisy && (c == 2 || c == 5);
            if (wr_cyc == c) begin
                w_we = 1'b1; w_addr = 3'(wr_a); w_data = 8'(wr_d);
            end
            @(posedge clk); #1;
            step = 1'b0; w_we = 1'b0;
            if (c < N) begin
                chk($sformatf("%s_valid_c%0d", tag, c), 32'(valid), 32'd0);
                chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'd1);
            end
        end
        if (wr_cyc > 0) w_m[wr_a] = wr_d;
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_post"}, 32'(post_synaptic), 32'(exp_ps));
        $display("scan %s spikes=%02h expected=%0d observed=%0d", tag, sp, exp_ps, post_synaptic);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int prev_post;
        for (int i = 0; i < N; i++) w_m[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_post", 32'(post_synaptic), 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < N; i++) write_w(i, i + 1);
        run_scan("w1to8_05", 8'h05, 0, 0, 0, 0);

        for (int i = 0; i < N; i++) write_w(i, 10 * (i + 1));
        run_scan("sat_ff", 8'hFF, 0, 0, 0, 0);
        run_scan("b2b_81", 8'h81, 0, 0, 0, 0);
        run_scan("zero_00", 8'h00, 0, 0, 0, 0);
        run_scan("noisy_81", 8'h81, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(valid), 32'd0);
        chk("post_hold", 32'(post_synaptic), 32'd90);

        for (int i = 0; i < N; i++) write_w(i, 0);
        run_scan("midwr_w7", 8'h80, 0, 3, 7, 100);
        write_w(3, 50);
        run_scan("samewr_w3", 8'h08, 0, 4, 3, 77);
        run_scan("after_w3", 8'h08, 0, 0, 0, 0);

        // reset mid-scan, colliding with a weight write and a step
        @(negedge clk); spike_in = 8'hFF; step = 1'b1;
        @(posedge clk); #1; step = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; step = 1'b1; w_we = 1'b1; w_addr = 3'd2; w_data = 8'd99;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_post", 32'(post_synaptic), 32'd0);
        @(negedge clk); reset = 1'b0; step = 1'b0; w_we = 1'b0;
        for (int i = 0; i < N; i++) w_m[i] = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_novalid_%0d", c), 32'(valid), 32'd0);
        end
        run_scan("post_rst_ff", 8'hFF, 0, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            int nwr;
            nwr = $urandom_range(0, 4);
            for (int k = 0; k < nwr; k++)
                write_w($urandom_range(0, 7), (t < 10) ? $urandom_range(0, 40) : $urandom_range(0, 255));
            prev_post = post_synaptic;
            run_scan($sformatf("rnd%0d", t), 8'($urandom), ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0,
                     $urandom_range(0, 7), $urandom_range(0, 255));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
